// File: rtl/n64_vdemux_gen.sv
// N64 VD bus demultiplexer: splits sync/colour phases framed by nVDSYNC into parallel
// pixels, flags malformed groups, and measures frame length / PAL / 480i / field status.
module n64_vdemux_gen #(
    parameter int COLOR_W    = 7,
    parameter int N_CH       = 3,
    parameter int MAX_PH     = 7,
    parameter int LCNT_W     = 10,
    parameter int PAL_THRESH = 288
) (
    input  logic                      i_vclk,
    input  logic                      i_vrst,
    input  logic                      i_nvdsync,
    input  logic [COLOR_W-1:0]        i_vd,
    output logic                      o_vdata_valid,
    output logic [3:0]                o_vdata_sync,
    output logic [N_CH*COLOR_W-1:0]   o_vdata_rgb,
    output logic                      o_phase_err,
    output logic [LCNT_W-1:0]         o_lines_per_frame,
    output logic                      o_frame_stat_vld,
    output logic                      o_palmode,
    output logic                      o_n64_480i,
    output logic                      o_field
);

    localparam int                PH_W    = $clog2(MAX_PH + 2);
    localparam logic [PH_W-1:0]   PH_IDLE = PH_W'(MAX_PH + 1);
    localparam logic [PH_W-1:0]   PH_MAX  = PH_W'(MAX_PH);
    localparam logic [PH_W-1:0]   PH_LAST = PH_W'(N_CH - 1);
    localparam logic [PH_W-1:0]   PH_NCH  = PH_W'(N_CH);
    localparam logic [LCNT_W-1:0] CNT_MAX = {LCNT_W{1'b1}};

    logic [PH_W-1:0]          r_ph;
    logic [3:0]               r_sync_tmp;
    logic [N_CH*COLOR_W-1:0]  w_rgb_next;
    logic                     w_sync_low;
    logic                     w_short;
    logic                     w_timeout;
    logic                     w_last;

    assign w_sync_low = ~i_nvdsync;
    assign w_short    = w_sync_low && (r_ph != '0) && (r_ph < PH_NCH);
    assign w_timeout  = i_nvdsync && (r_ph == PH_MAX);
    assign w_last     = i_nvdsync && (r_ph == PH_LAST);

    // The last colour phase bypasses the buffer so the pixel is presented one cycle after it.
    generate
        if (N_CH > 1) begin : g_buf
            logic [(N_CH-1)*COLOR_W-1:0] r_buf;
            always_ff @(posedge i_vclk) begin
                if (i_vrst) begin
                    r_buf <= '0;
                end else if (i_nvdsync) begin
                    for (int c = 0; c < N_CH - 1; c++) begin
                        if (r_ph == PH_W'(c))
                            r_buf[(N_CH-2-c)*COLOR_W +: COLOR_W] <= i_vd;
                    end
                end
            end
            assign w_rgb_next = {r_buf, i_vd};
        end else begin : g_nobuf
            assign w_rgb_next = i_vd;
        end
    endgenerate

    always_ff @(posedge i_vclk) begin
        if (i_vrst) begin
            r_ph          <= PH_IDLE;
            r_sync_tmp    <= '0;
            o_vdata_valid <= 1'b0;
            o_phase_err   <= 1'b0;
            o_vdata_sync  <= 4'hF;
            o_vdata_rgb   <= '0;
        end else begin
            o_vdata_valid <= w_last;
            o_phase_err   <= w_short | w_timeout;
            if (w_sync_low) begin
                r_ph       <= '0;
                r_sync_tmp <= i_vd[3:0];
            end else if (r_ph != PH_IDLE) begin
                r_ph <= r_ph + 1'b1;
            end
            if (w_last) begin
                o_vdata_rgb  <= w_rgb_next;
                o_vdata_sync <= r_sync_tmp;
            end
        end
    end

    logic                r_prev_vs;
    logic                r_prev_hs;
    logic [LCNT_W-1:0]   r_hcnt;
    logic [1:0]          r_frames;
    logic                w_hs_fall;
    logic                w_vs_fall;
    logic [LCNT_W:0]     w_len_full;
    logic [LCNT_W-1:0]   w_len;
    logic [LCNT_W:0]     w_len_p1;
    logic [LCNT_W:0]     w_lpf_p1;
    logic                w_adj;

    assign w_hs_fall  = r_prev_hs & ~o_vdata_sync[1];
    assign w_vs_fall  = r_prev_vs & ~o_vdata_sync[3];
    // An hsync edge sharing the group with vsync belongs to the frame that is ending.
    assign w_len_full = {1'b0, r_hcnt} + {{LCNT_W{1'b0}}, w_hs_fall};
    assign w_len      = w_len_full[LCNT_W] ? CNT_MAX : w_len_full[LCNT_W-1:0];
    assign w_len_p1   = {1'b0, w_len} + {{LCNT_W{1'b0}}, 1'b1};
    assign w_lpf_p1   = {1'b0, o_lines_per_frame} + {{LCNT_W{1'b0}}, 1'b1};
    assign w_adj      = (w_len_p1 == {1'b0, o_lines_per_frame}) ||
                        (w_lpf_p1 == {1'b0, w_len});

    always_ff @(posedge i_vclk) begin
        if (i_vrst) begin
            r_prev_vs         <= 1'b1;
            r_prev_hs         <= 1'b1;
            r_hcnt            <= '0;
            r_frames          <= '0;
            o_lines_per_frame <= '0;
            o_frame_stat_vld  <= 1'b0;
            o_palmode         <= 1'b0;
            o_n64_480i        <= 1'b0;
            o_field           <= 1'b0;
        end else if (o_vdata_valid) begin
            r_prev_vs <= o_vdata_sync[3];
            r_prev_hs <= o_vdata_sync[1];
            if (w_vs_fall) begin
                r_hcnt <= '0;
                if (r_frames != 2'd3)
                    r_frames <= r_frames + 2'd1;
                if (r_frames != 2'd0) begin
                    o_lines_per_frame <= w_len;
                    o_palmode         <= (w_len > LCNT_W'(PAL_THRESH));
                    o_frame_stat_vld  <= 1'b1;
                end
                if (r_frames >= 2'd2) begin
                    o_n64_480i <= w_adj;
                    o_field    <= w_adj && (w_len < o_lines_per_frame);
                end
            end else if (w_hs_fall && (r_hcnt != CNT_MAX)) begin
                r_hcnt <= r_hcnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_n64_vdemux_gen.sv
// Randomized bench for n64_vdemux_gen: group-level stimulus checked against a
// frame-level reference model of pixel output, phase errors and timing status.
module tb_n64_vdemux_gen;

    localparam int CW    = 7;
    localparam int NCH   = 3;
    localparam int MAXPH = 7;
    localparam int LW    = 10;
    localparam int PALT  = 288;
    localparam int LMAX  = (1 << LW) - 1;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               nvd = 1'b1;
    logic [CW-1:0]      vd  = '0;
    logic               o_valid;
    logic [3:0]         o_sync;
    logic [NCH*CW-1:0]  o_rgb;
    logic               o_err;
    logic [LW-1:0]      o_lpf;
    logic               o_vld;
    logic               o_pal;
    logic               o_i;
    logic               o_fld;

    n64_vdemux_gen #(
        .COLOR_W(CW), .N_CH(NCH), .MAX_PH(MAXPH), .LCNT_W(LW), .PAL_THRESH(PALT)
    ) dut (
        .i_vclk(clk), .i_vrst(rst), .i_nvdsync(nvd), .i_vd(vd),
        .o_vdata_valid(o_valid), .o_vdata_sync(o_sync), .o_vdata_rgb(o_rgb),
        .o_phase_err(o_err), .o_lines_per_frame(o_lpf), .o_frame_stat_vld(o_vld),
        .o_palmode(o_pal), .o_n64_480i(o_i), .o_field(o_fld)
    );

    always #5 clk = ~clk;

    int n_err = 0;
    int n_chk = 0;

    // reference model state (one update per accepted group)
    logic [3:0] m_prev = 4'hF;
    int m_hcnt = 0, m_frames = 0, m_lpf = 0;
    bit m_pal = 0, m_i = 0, m_fld = 0, m_vld = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, obs, obs, exp, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_prev = 4'hF; m_hcnt = 0; m_frames = 0; m_lpf = 0;
        m_pal = 0; m_i = 0; m_fld = 0; m_vld = 0;
    endtask

    task automatic model_accept(input logic [3:0] s);
        bit hs, vs;
        int len;
        hs = m_prev[1] && !s[1];
        vs = m_prev[3] && !s[3];
        if (vs) begin
            len = m_hcnt + int'(hs);
            if (len > LMAX) len = LMAX;
            if (m_frames >= 2) begin
                m_i   = (len - m_lpf == 1) || (m_lpf - len == 1);
                m_fld = m_i && (len < m_lpf);
            end
            if (m_frames >= 1) begin
                m_lpf = len;
                m_pal = (len > PALT);
                m_vld = 1;
            end
            m_hcnt = 0;
            if (m_frames < 3) m_frames++;
        end else if (hs && m_hcnt < LMAX) begin
            m_hcnt++;
        end
        m_prev = s;
    endtask

    task automatic check_status();
        chk("lines_per_frame", o_lpf, m_lpf);
        chk("palmode", o_pal, m_pal);
        chk("n64_480i", o_i, m_i);
        chk("field", o_fld, m_fld);
        chk("frame_stat_vld", o_vld, m_vld);
    endtask

    task automatic check_reset_values();
        chk("rst_valid", o_valid, 0);
        chk("rst_sync", o_sync, 4'hF);
        chk("rst_rgb", o_rgb, 0);
        chk("rst_err", o_err, 0);
        chk("rst_lpf", o_lpf, 0);
        chk("rst_vld", o_vld, 0);
        chk("rst_pal", o_pal, 0);
        chk("rst_480i", o_i, 0);
        chk("rst_field", o_fld, 0);
    endtask

    task automatic send_group(input logic [3:0] s, input logic [CW-1:0] r, input logic [CW-1:0] g,
                              input logic [CW-1:0] b, input int extra, input bit exp_err_first);
        logic [NCH*CW-1:0] exp_rgb;
        nvd = 1'b0;
        vd = CW'($urandom);
        vd[3:0] = s;
        tick();
        if (exp_err_first) begin
            chk("short_err", o_err, 1);
            chk("short_no_valid", o_valid, 0);
        end
        nvd = 1'b1;
        vd = r; tick();
        vd = g; tick();
        vd = b; tick();
        model_accept(s);
        exp_rgb = {r, g, b};
        chk("valid", o_valid, 1);
        chk("rgb", o_rgb, exp_rgb);
        chk("sync", o_sync, s);
        chk("err_on_valid", o_err, 0);
        for (int i = 0; i < extra; i++) begin
            vd = CW'($urandom);
            tick();
            if (i == 0) chk("valid_pulse", o_valid, 0);
            chk("extra_no_err", o_err, 0);
        end
        check_status();
    endtask

    task automatic send_rand(input logic [3:0] s);
        send_group(s, CW'($urandom), CW'($urandom), CW'($urandom), $urandom_range(2, 1), 1'b0);
    endtask

    task automatic send_line(input bit nvs);
        send_rand({nvs, 1'($urandom), 1'b0, 1'($urandom)});
        send_rand({nvs, 1'($urandom), 1'b1, 1'($urandom)});
    endtask

    // Opens a frame with a vsync group, then L hsync pulses; merge puts an hsync
    // edge into the vsync group itself.
    task automatic send_frame(input int L, input bit merge);
        if (merge) begin
            send_rand({1'b0, 1'($urandom), 1'b0, 1'($urandom)});
            send_rand({1'b0, 1'($urandom), 1'b1, 1'($urandom)});
        end else begin
            send_rand({1'b0, 1'($urandom), 1'b1, 1'($urandom)});
        end
        for (int i = 0; i < L; i++) send_line(i >= 3);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        int errs, vals, err_at;
        rst = 1'b1; nvd = 1'b1;
        repeat (3) tick();
        check_reset_values();
        rst = 1'b0;
        tick();
        chk("idle_no_err", o_err, 0);

        // basic group
        send_group(4'hF, 7'h11, 7'h22, 7'h33, 1, 1'b0);
        for (int k = 0; k < 6; k++)
            send_group(4'hF, CW'($urandom), CW'($urandom), CW'($urandom), $urandom_range(MAXPH - NCH, 1), 1'b0);

        // short group: sync, R, then sync again
        nvd = 1'b0; vd = 7'h0F; tick();
        nvd = 1'b1; vd = 7'h55; tick();
        send_group(4'hF, 7'h01, 7'h02, 7'h03, 1, 1'b1);

        // nVDSYNC held high too long after sync
        nvd = 1'b0; vd = 7'h0F; tick();
        nvd = 1'b1;
        errs = 0; vals = 0; err_at = -1;
        for (int i = 1; i <= 9; i++) begin
            vd = CW'($urandom);
            tick();
            if (o_err) begin errs++; err_at = i; end
            if (o_valid) vals++;
        end
        model_accept(4'hF);
        chk("timeout_err_count", errs, 1);
        chk("timeout_err_cycle", err_at, MAXPH + 1);
        chk("timeout_valid_count", vals, 1);
        errs = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (o_err || o_valid) errs++;
        end
        chk("idle_silent", errs, 0);
        send_group(4'hF, 7'h44, 7'h55, 7'h66, 1, 1'b0);

        // NTSC 240p
        send_frame(263, 0);
        chk("pre_store_vld", o_vld, 0);
        send_frame(263, 0);
        chk("ntsc_lpf", o_lpf, 263);
        chk("ntsc_pal", o_pal, 0);
        chk("ntsc_vld", o_vld, 1);
        send_frame(263, 0);
        chk("ntsc_480i", o_i, 0);

        // interlaced NTSC then PAL
        send_frame(262, 0);
        send_frame(263, 0);
        chk("i_lpf_262", o_lpf, 262);
        chk("i_480i_a", o_i, 1);
        chk("i_field_a", o_fld, 1);
        send_frame(262, 0);
        chk("i_field_b", o_fld, 0);
        send_frame(312, 0);
        chk("i_field_c", o_fld, 1);
        send_frame(313, 0);
        chk("pal_lpf_312", o_lpf, 312);
        chk("pal_mode_a", o_pal, 1);
        chk("pal_480i_a", o_i, 0);
        send_frame(312, 0);
        chk("pal_lpf_313", o_lpf, 313);
        chk("pal_480i_b", o_i, 1);
        chk("pal_field_b", o_fld, 0);
        send_frame(100, 0);
        chk("pal_field_c", o_fld, 1);

        // hsync and vsync in the same group
        send_frame(10, 1);
        chk("merge_lpf", o_lpf, 101);
        chk("merge_pal", o_pal, 0);
        send_frame(10, 0);
        chk("merge_next_lpf", o_lpf, 10);

        // reset in the middle of a frame and a group
        send_frame(40, 0);
        nvd = 1'b0; vd = 7'h07; tick();
        nvd = 1'b1; vd = 7'h2A; tick();
        rst = 1'b1; tick();
        rst = 1'b0;
        check_reset_values();
        model_reset();
        vals = 0;
        for (int i = 0; i < 5; i++) begin
            vd = CW'($urandom);
            tick();
            if (o_valid || o_err) vals++;
        end
        chk("post_rst_quiet", vals, 0);
        send_frame(20, 0);
        chk("post_rst_vld_first", o_vld, 0);
        send_frame(20, 0);
        chk("post_rst_vld_second", o_vld, 1);
        chk("post_rst_lpf", o_lpf, 20);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
